// File: rtl/cmac_tx_axis_arbiter.sv
// cmac_tx_axis_arbiter: packet-granular 2:1 AXI-Stream arbiter (XDMA H2C vs UDP perf monitor)
// feeding the CMAC TX buffer through a full-throughput registered output slice.
`timescale 1ns/1ps
module cmac_tx_axis_arbiter #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = 64,
   parameter int USER_WIDTH = 1,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  s0_axis_tvalid,
   output logic                  s0_axis_tready,
   input  logic                  s0_axis_tlast,
   input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
   input  logic [USER_WIDTH-1:0] s0_axis_tuser,
   input  logic                  s1_axis_tvalid,
   output logic                  s1_axis_tready,
   input  logic                  s1_axis_tlast,
   input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
   input  logic [USER_WIDTH-1:0] s1_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   input  logic [1:0]            src_en,
   input  logic                  prio_mode,
   output logic [1:0]            grant_out,
   output logic [CNT_WIDTH-1:0]  pkt_cnt_0,
   output logic [CNT_WIDTH-1:0]  pkt_cnt_1
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t state;
   logic rr_last;
   logic req0, req1, slot, hs0, hs1, arb, any_req, sel1;
   always_comb begin
      req0 = s0_axis_tvalid & src_en[0];
      req1 = s1_axis_tvalid & src_en[1];
      slot = ~m_axis_tvalid | m_axis_tready;
      s0_axis_tready = (state == OWN0) & slot;
      s1_axis_tready = (state == OWN1) & slot;
      hs0 = s0_axis_tvalid & s0_axis_tready;
      hs1 = s1_axis_tvalid & s1_axis_tready;
      // the owner's tlast cycle is an arbitration point so packets go back-to-back
      arb = (state == IDLE) | (hs0 & s0_axis_tlast) | (hs1 & s1_axis_tlast);
      any_req = req0 | req1;
      sel1 = prio_mode ? ~req0 : ((req0 & req1) ? ~rr_last : req1);
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         rr_last <= 1'b1;
         grant_out <= 2'b00;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tkeep <= '0;
         m_axis_tuser <= '0;
         pkt_cnt_0 <= '0;
         pkt_cnt_1 <= '0;
      end else begin
         if (arb) begin
            state <= any_req ? (sel1 ? OWN1 : OWN0) : IDLE;
            grant_out <= any_req ? (sel1 ? 2'b10 : 2'b01) : 2'b00;
            if (any_req) rr_last <= sel1;
         end
         if (hs0 | hs1) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast <= hs1 ? s1_axis_tlast : s0_axis_tlast;
            m_axis_tdata <= hs1 ? s1_axis_tdata : s0_axis_tdata;
            m_axis_tkeep <= hs1 ? s1_axis_tkeep : s0_axis_tkeep;
            m_axis_tuser <= hs1 ? s1_axis_tuser : s0_axis_tuser;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (hs0 & s0_axis_tlast) pkt_cnt_0 <= pkt_cnt_0 + CNT_WIDTH'(1);
         if (hs1 & s1_axis_tlast) pkt_cnt_1 <= pkt_cnt_1 + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_cmac_tx_axis_arbiter.sv
// tb_cmac_tx_axis_arbiter: randomized scoreboard bench; per-source expected queues are popped
// by an output monitor keyed on the source tag carried in tdata[511].
`timescale 1ns/1ps
module tb_cmac_tx_axis_arbiter;
   localparam int DW = 512, KW = 64, UW = 1, CW = 32;
   logic CLK = 0, RST_N = 0;
   logic s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
   logic [DW-1:0] s0_axis_tdata;
   logic [KW-1:0] s0_axis_tkeep;
   logic [UW-1:0] s0_axis_tuser;
   logic s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
   logic [DW-1:0] s1_axis_tdata;
   logic [KW-1:0] s1_axis_tkeep;
   logic [UW-1:0] s1_axis_tuser;
   logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic [UW-1:0] m_axis_tuser;
   logic [1:0] src_en, grant_out;
   logic prio_mode;
   logic [CW-1:0] pkt_cnt_0, pkt_cnt_1;
   // small-counter instance used only to exercise counter wrap
   logic w_s0_tvalid, w_s0_tready, w_s1_tready, w_m_tvalid, w_m_tlast;
   logic [DW-1:0] w_m_tdata;
   logic [KW-1:0] w_m_tkeep;
   logic [UW-1:0] w_m_tuser;
   logic [1:0] w_grant;
   logic [3:0] w_cnt0, w_cnt1;

   always #5 CLK = ~CLK;

   cmac_tx_axis_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready), .s0_axis_tlast(s0_axis_tlast),
      .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tuser(s0_axis_tuser),
      .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready), .s1_axis_tlast(s1_axis_tlast),
      .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tuser(s1_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
      .src_en(src_en), .prio_mode(prio_mode), .grant_out(grant_out),
      .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1));

   cmac_tx_axis_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .CNT_WIDTH(4)) u_wrap (
      .CLK(CLK), .RST_N(RST_N),
      .s0_axis_tvalid(w_s0_tvalid), .s0_axis_tready(w_s0_tready), .s0_axis_tlast(1'b1),
      .s0_axis_tdata('0), .s0_axis_tkeep('0), .s0_axis_tuser('0),
      .s1_axis_tvalid(1'b0), .s1_axis_tready(w_s1_tready), .s1_axis_tlast(1'b0),
      .s1_axis_tdata('0), .s1_axis_tkeep('0), .s1_axis_tuser('0),
      .m_axis_tvalid(w_m_tvalid), .m_axis_tready(1'b1), .m_axis_tlast(w_m_tlast),
      .m_axis_tdata(w_m_tdata), .m_axis_tkeep(w_m_tkeep), .m_axis_tuser(w_m_tuser),
      .src_en(2'b01), .prio_mode(1'b0), .grant_out(w_grant),
      .pkt_cnt_0(w_cnt0), .pkt_cnt_1(w_cnt1));

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic l;
   } beat_t;
   beat_t q0[$], q1[$];
   int order[$];
   int errors = 0, checks = 0;
   int cyc = 0, out_cnt = 0, first_cyc = 0, last_cyc = 0, pkt_id = 0;
   bit in_pkt = 0, rand_ready = 0;
   int cur_src = 0;

   task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic beat_t mk_beat(input int src, input int b, input int len, input int id);
      beat_t e;
      e.d = '0;
      e.d[31:0] = b;
      e.d[63:32] = id;
      e.d[95:64] = $urandom;
      e.d[DW-1] = src[0];
      e.k = {$urandom, $urandom};
      e.u = UW'($urandom);
      e.l = (b == len - 1);
      return e;
   endfunction

   task automatic drive(input int src, input logic v, input beat_t e);
      if (src != 0) begin
         s1_axis_tvalid = v; s1_axis_tdata = e.d; s1_axis_tkeep = e.k; s1_axis_tuser = e.u; s1_axis_tlast = e.l;
      end else begin
         s0_axis_tvalid = v; s0_axis_tdata = e.d; s0_axis_tkeep = e.k; s0_axis_tuser = e.u; s0_axis_tlast = e.l;
      end
   endtask

   task automatic wait_accept(input int src, output bit acc);
      int n;
      n = 0;
      acc = 0;
      while (!acc && n < 3000) begin
         @(negedge CLK);
         acc = (src != 0) ? (s1_axis_tvalid && s1_axis_tready) : (s0_axis_tvalid && s0_axis_tready);
         @(posedge CLK); #1;
         n++;
      end
      if (!acc) check("accept_timeout", 1'b0, 64'(n), 64'd0);
   endtask

   // rel: drop this source's enable just before its last beat
   task automatic send(input int src, input int len, input bit gaps, input bit rel);
      beat_t e;
      bit acc;
      int id;
      id = ++pkt_id;
      for (int b = 0; b < len; b++) begin
         if (gaps && b > 0 && $urandom_range(3) == 0) begin
            if (src != 0) s1_axis_tvalid = 0; else s0_axis_tvalid = 0;
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
         end
         e = mk_beat(src, b, len, id);
         if (rel && b == len - 1) src_en[src] = 1'b0;
         drive(src, 1'b1, e);
         wait_accept(src, acc);
         if (!acc) return;
         if (src != 0) q1.push_back(e); else q0.push_back(e);
      end
   endtask

   task automatic reset_dut();
      RST_N = 0;
      s0_axis_tvalid = 0;
      s1_axis_tvalid = 0;
      q0.delete(); q1.delete(); order.delete();
      out_cnt = 0;
      in_pkt = 0;
      repeat (2) @(negedge CLK);
      RST_N = 1;
      @(posedge CLK); #1;
   endtask

   // output monitor / scoreboard
   initial begin
      logic [DW+KW+UW+1:0] prev_bits;
      bit pv, pr;
      int s, sz;
      beat_t e;
      pv = 0; pr = 0; prev_bits = '0;
      forever begin
         @(negedge CLK);
         cyc++;
         if (!RST_N) begin
            in_pkt = 0;
            pv = 0;
         end else begin
            if (pv && !pr)
               check("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} === prev_bits,
                     m_axis_tdata[63:0], prev_bits[KW+UW+64:KW+UW+1]);
            if (m_axis_tvalid && m_axis_tready) begin
               s = int'(m_axis_tdata[DW-1]);
               if (in_pkt) check("no_interleave", s == cur_src, 64'(s), 64'(cur_src));
               sz = (s != 0) ? q1.size() : q0.size();
               check("beat_expected", sz != 0, 64'(sz), 64'd1);
               if (sz != 0) begin
                  e = (s != 0) ? q1.pop_front() : q0.pop_front();
                  check("beat_match", m_axis_tdata === e.d && m_axis_tkeep === e.k && m_axis_tuser === e.u && m_axis_tlast === e.l,
                        m_axis_tdata[63:0], e.d[63:0]);
               end
               out_cnt++;
               if (out_cnt == 1) first_cyc = cyc;
               last_cyc = cyc;
               if (m_axis_tlast) begin
                  order.push_back(s);
                  in_pkt = 0;
               end else begin
                  in_pkt = 1;
                  cur_src = s;
               end
            end
            pv = m_axis_tvalid;
            pr = m_axis_tready;
            prev_bits = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
         end
      end
   end

   initial forever begin
      @(posedge CLK); #1;
      if (rand_ready) m_axis_tready = 1'($urandom_range(1));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t e;
      bit acc;
      s0_axis_tvalid = 0; s0_axis_tlast = 0; s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tuser = '0;
      s1_axis_tvalid = 0; s1_axis_tlast = 0; s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tuser = '0;
      m_axis_tready = 1; src_en = 2'b00; prio_mode = 0; w_s0_tvalid = 0;
      RST_N = 0;
      repeat (2) @(negedge CLK);
      check("rst_m_tvalid", m_axis_tvalid == 1'b0, 64'(m_axis_tvalid), 64'd0);
      check("rst_m_tdata", m_axis_tdata == '0 && m_axis_tlast == 1'b0, m_axis_tdata[63:0], 64'd0);
      check("rst_grant", grant_out == 2'b00, 64'(grant_out), 64'd0);
      check("rst_cnt0", pkt_cnt_0 == '0, 64'(pkt_cnt_0), 64'd0);
      check("rst_cnt1", pkt_cnt_1 == '0, 64'(pkt_cnt_1), 64'd0);
      check("rst_treadys", {s0_axis_tready, s1_axis_tready} == 2'b00, 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
      RST_N = 1;
      @(posedge CLK); #1;

      // single source, 4-beat packet; enable dropped on the last beat so the grant returns to idle
      src_en = 2'b01;
      fork
         send(0, 4, 0, 1);
         begin
            repeat (3) @(negedge CLK);
            check("t1_grant_mid", grant_out == 2'b01, 64'(grant_out), 64'd1);
         end
      join
      check("t1_last_latency", m_axis_tvalid && m_axis_tlast, 64'({m_axis_tvalid, m_axis_tlast}), 64'd3);
      check("t1_last_data", m_axis_tdata[31:0] == 32'd3, 64'(m_axis_tdata[31:0]), 64'd3);
      check("t1_grant_idle", grant_out == 2'b00, 64'(grant_out), 64'd0);
      check("t1_cnt0", pkt_cnt_0 == 1, 64'(pkt_cnt_0), 64'd1);
      s0_axis_tvalid = 0;
      repeat (3) @(posedge CLK); #1;
      check("t1_drained", q0.size() == 0 && order.size() == 1, 64'(order.size()), 64'd1);

      // round-robin, both continuously valid
      reset_dut();
      src_en = 2'b11; prio_mode = 0;
      fork
         begin for (int i = 0; i < 4; i++) send(0, 3, 0, 0); s0_axis_tvalid = 0; end
         begin for (int i = 0; i < 4; i++) send(1, 3, 0, 0); s1_axis_tvalid = 0; end
      join
      repeat (4) @(posedge CLK); #1;
      check("t2_cnt0", pkt_cnt_0 == 4, 64'(pkt_cnt_0), 64'd4);
      check("t2_cnt1", pkt_cnt_1 == 4, 64'(pkt_cnt_1), 64'd4);
      for (int i = 0; i < 8; i++)
         check("t2_order", order.size() > i && order[i] == i % 2, 64'(order.size() > i ? order[i] : -1), 64'(i % 2));
      check("t2_no_bubble", last_cyc - first_cyc + 1 == 24, 64'(last_cyc - first_cyc + 1), 64'd24);

      // strict priority; src_en[0] dropped mid third packet hands over at its tlast
      reset_dut();
      src_en = 2'b11; prio_mode = 1;
      fork
         begin
            send(0, 2, 0, 0);
            send(0, 2, 0, 0);
            check("t3_s1_starved", pkt_cnt_1 == 0, 64'(pkt_cnt_1), 64'd0);
            send(0, 2, 0, 1);
            s0_axis_tvalid = 0;
         end
         begin send(1, 2, 0, 0); s1_axis_tvalid = 0; end
      join
      repeat (4) @(posedge CLK); #1;
      check("t3_cnt0", pkt_cnt_0 == 3, 64'(pkt_cnt_0), 64'd3);
      check("t3_cnt1", pkt_cnt_1 == 1, 64'(pkt_cnt_1), 64'd1);
      for (int i = 0; i < 4; i++)
         check("t3_order", order.size() > i && order[i] == (i == 3 ? 1 : 0), 64'(order.size() > i ? order[i] : -1), 64'(i == 3));

      // random lengths, gaps and backpressure
      reset_dut();
      src_en = 2'b11; prio_mode = 0; rand_ready = 1;
      fork
         begin for (int i = 0; i < 50; i++) send(0, $urandom_range(1, 16), 1, 0); s0_axis_tvalid = 0; end
         begin for (int i = 0; i < 50; i++) send(1, $urandom_range(1, 16), 1, 0); s1_axis_tvalid = 0; end
      join
      rand_ready = 0;
      m_axis_tready = 1;
      repeat (5) @(posedge CLK); #1;
      check("t4_q0_empty", q0.size() == 0, 64'(q0.size()), 64'd0);
      check("t4_q1_empty", q1.size() == 0, 64'(q1.size()), 64'd0);
      check("t4_pkts", order.size() == 100, 64'(order.size()), 64'd100);
      check("t4_cnt0", pkt_cnt_0 == 50, 64'(pkt_cnt_0), 64'd50);
      check("t4_cnt1", pkt_cnt_1 == 50, 64'(pkt_cnt_1), 64'd50);

      // reset asserted during beat 2 of a 5-beat s1 packet
      reset_dut();
      src_en = 2'b11; prio_mode = 0; m_axis_tready = 1;
      send(0, 2, 0, 1);
      s0_axis_tvalid = 0;
      src_en = 2'b11;
      e = mk_beat(1, 0, 5, 999);
      drive(1, 1'b1, e);
      wait_accept(1, acc);
      if (acc) q1.push_back(e);
      drive(1, 1'b1, mk_beat(1, 1, 5, 999));
      #3;
      check("t5_pre_valid", m_axis_tvalid == 1'b1, 64'(m_axis_tvalid), 64'd1);
      check("t5_pre_cnt0", pkt_cnt_0 == 1, 64'(pkt_cnt_0), 64'd1);
      RST_N = 0;
      #1;
      check("t5_rst_valid", m_axis_tvalid == 1'b0, 64'(m_axis_tvalid), 64'd0);
      check("t5_rst_grant", grant_out == 2'b00, 64'(grant_out), 64'd0);
      check("t5_rst_cnts", pkt_cnt_0 == 0 && pkt_cnt_1 == 0, 64'(pkt_cnt_0), 64'd0);
      check("t5_rst_tready", s1_axis_tready == 1'b0, 64'(s1_axis_tready), 64'd0);
      reset_dut();
      src_en = 2'b11;
      send(0, 3, 0, 1);
      s0_axis_tvalid = 0;
      repeat (3) @(posedge CLK); #1;
      check("t5_after_pkts", order.size() == 1 && order[0] == 0, 64'(order.size()), 64'd1);
      check("t5_after_cnt0", pkt_cnt_0 == 1, 64'(pkt_cnt_0), 64'd1);
      check("t5_after_q", q0.size() == 0 && q1.size() == 0, 64'(q0.size() + q1.size()), 64'd0);

      // counter wrap on the 4-bit instance: single-beat packets every cycle after the grant
      w_s0_tvalid = 1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge CLK); #1;
         check("t6_wrap_cnt", w_cnt0 == 4'((n - 1) % 16), 64'(w_cnt0), 64'((n - 1) % 16));
      end
      w_s0_tvalid = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
